// File: rtl/rob_multi_issue.sv
// Multi-issue reorder buffer: in-order dispatch, out-of-order writeback, in-order commit.
// Optional ROB_EXC_FLUSH_EN: committing an exception entry also discards every younger entry.
module rob_multi_issue #(
    parameter int DEPTH  = 32,
    parameter int DISP_W = 2,
    parameter int WB_W   = 2,
    parameter int CMT_W  = 2,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [DISP_W-1:0]        disp_valid,
    input  logic [DISP_W*DATA_W-1:0] disp_payload,
    output logic                     disp_ready,
    output logic [DISP_W*IDX_W-1:0]  disp_idx,
    input  logic [WB_W-1:0]          wb_valid,
    input  logic [WB_W*IDX_W-1:0]    wb_idx,
    input  logic [WB_W-1:0]          wb_exc,
    output logic [CMT_W-1:0]         cmt_valid,
    output logic [CMT_W*DATA_W-1:0]  cmt_payload,
    output logic [CMT_W-1:0]         cmt_exc,
    input  logic                     cmt_ready,
    output logic [IDX_W:0]           count,
    output logic                     empty,
    output logic                     full
);
    localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0] DISP_C  = (IDX_W+1)'(DISP_W);
    localparam logic [IDX_W:0] ZERO_C  = {(IDX_W+1){1'b0}};

    logic [IDX_W:0]    head_q, head_d, tail_q, tail_d;
    logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d, exc_q, exc_d;
    logic [DATA_W-1:0] payload_q [DEPTH];
    logic [IDX_W-1:0]  head_idx_s, tail_idx_s;
    logic [IDX_W:0]    free_s, disp_cnt_s, cmt_cnt_s;
    logic              exc_flush_s, kill_s;

    assign head_idx_s = head_q[IDX_W-1:0];
    assign tail_idx_s = tail_q[IDX_W-1:0];
    assign count      = tail_q - head_q;
    assign empty      = (count == ZERO_C);
    assign full       = (count == DEPTH_C);
    assign free_s     = DEPTH_C - count;
    // Free space is judged on registered occupancy only, so retiring entries are not reusable yet.
    assign disp_ready = (free_s >= DISP_C) && !flush;

    // Allocation indices for each dispatch lane
    always_comb begin
        for (int i = 0; i < DISP_W; i++) begin
            disp_idx[i*IDX_W +: IDX_W] = tail_idx_s + IDX_W'(i);
        end
    end

    // Lane popcounts for pointer advance
    always_comb begin
        disp_cnt_s = ZERO_C;
        cmt_cnt_s  = ZERO_C;
        for (int i = 0; i < DISP_W; i++) begin
            disp_cnt_s = disp_cnt_s + (IDX_W+1)'(disp_valid[i]);
        end
        for (int i = 0; i < CMT_W; i++) begin
            cmt_cnt_s = cmt_cnt_s + (IDX_W+1)'(cmt_valid[i]);
        end
    end

    // Commit group selection: a contiguous run of done entries, an exception only ever in lane 0
    always_comb begin : cmt_sel
        logic                 chain_s;
        logic [IDX_W-1:0]     sel_s;
        cmt_valid   = {CMT_W{1'b0}};
        cmt_exc     = {CMT_W{1'b0}};
        cmt_payload = {(CMT_W*DATA_W){1'b0}};
        chain_s     = 1'b1;
        sel_s       = head_idx_s;
        for (int i = 0; i < CMT_W; i++) begin
            sel_s = head_idx_s + IDX_W'(i);
            if (chain_s && valid_q[sel_s] && done_q[sel_s] && ((i == 0) || !exc_q[sel_s])) begin
                cmt_valid[i]                      = 1'b1;
                cmt_exc[i]                        = exc_q[sel_s];
                cmt_payload[i*DATA_W +: DATA_W]   = payload_q[sel_s];
                chain_s                           = !exc_q[sel_s];
            end else begin
                chain_s = 1'b0;
            end
        end
    end

`ifdef ROB_EXC_FLUSH_EN
    assign exc_flush_s = cmt_ready && cmt_valid[0] && cmt_exc[0];
`else
    assign exc_flush_s = 1'b0;
`endif
    assign kill_s = flush || exc_flush_s;

    // Next-state: writeback, then commit clear, then dispatch allocate (targets are disjoint)
    always_comb begin : nxt
        logic [IDX_W-1:0] sel_s;
        logic             hit_s;
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        done_d  = done_q;
        exc_d   = exc_q;
        sel_s   = head_idx_s;
        hit_s   = 1'b0;
        if (kill_s) begin
            head_d  = ZERO_C;
            tail_d  = ZERO_C;
            valid_d = {DEPTH{1'b0}};
            done_d  = {DEPTH{1'b0}};
            exc_d   = {DEPTH{1'b0}};
        end else begin
            for (int k = 0; k < WB_W; k++) begin
                sel_s         = wb_idx[k*IDX_W +: IDX_W];
                hit_s         = wb_valid[k] && valid_q[sel_s];
                done_d[sel_s] = done_d[sel_s] | hit_s;
                exc_d[sel_s]  = exc_d[sel_s] | (hit_s & wb_exc[k]);
            end
            for (int i = 0; i < CMT_W; i++) begin
                sel_s          = head_idx_s + IDX_W'(i);
                hit_s          = cmt_ready && cmt_valid[i];
                valid_d[sel_s] = valid_d[sel_s] & ~hit_s;
                done_d[sel_s]  = done_d[sel_s] & ~hit_s;
                exc_d[sel_s]   = exc_d[sel_s] & ~hit_s;
            end
            for (int i = 0; i < DISP_W; i++) begin
                sel_s          = tail_idx_s + IDX_W'(i);
                hit_s          = disp_ready && disp_valid[i];
                valid_d[sel_s] = valid_d[sel_s] | hit_s;
                done_d[sel_s]  = done_d[sel_s] & ~hit_s;
                exc_d[sel_s]   = exc_d[sel_s] & ~hit_s;
            end
            head_d = head_q + (cmt_ready ? cmt_cnt_s : ZERO_C);
            tail_d = tail_q + (disp_ready ? disp_cnt_s : ZERO_C);
        end
    end

    // Pointer and per-entry status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= ZERO_C;
            tail_q  <= ZERO_C;
            valid_q <= {DEPTH{1'b0}};
            done_q  <= {DEPTH{1'b0}};
            exc_q   <= {DEPTH{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            exc_q   <= exc_d;
        end
    end

    // Payload storage; stale contents are harmless because commit output is gated by valid
    always_ff @(posedge clk) begin
        for (int i = 0; i < DISP_W; i++) begin
            if (disp_ready && disp_valid[i]) begin
                payload_q[tail_idx_s + IDX_W'(i)] <= disp_payload[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule
